fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined RV32I core, directly upstream of memoriaROM. It owns the program counter and drives the ROM word address. It samples the combinational ROM output and registers it, with its PC, into the IF/ID pipeline register. Stall, branch/jump redirect and bubble insertion are handled here; decode consumes the IF/ID outputs.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/ifid_reg.sv | 40 ++++
 rtl/fetch_stage.sv | 94 +++++++++
 tb/tb_fetch_stage.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I pipeline stages.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  typedef enum logic {BOOT, RUN} fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with hold and flush; flush beats hold and keeps the old PC.
module ifid_reg
  import riscv_pkg::*;
#(
  parameter logic [31:0] RstPc       = 32'h0000_0000,
  parameter logic [31:0] BubbleInstr = 32'h0000_0013
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  hold_i,
  input  logic  flush_i,
  input  ifid_t d_i,
  output ifid_t q_o
);

  ifid_t ifid_d, ifid_q;

  always_comb begin
    ifid_d = ifid_q;
    if (flush_i) begin
      ifid_d.instr = BubbleInstr;
      ifid_d.valid = 1'b0;
    end else if (!hold_i) begin
      ifid_d = d_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ifid_q.pc    <= RstPc;
      ifid_q.instr <= BubbleInstr;
      ifid_q.valid <= 1'b0;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign q_o = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, addresses the ROM and fills the IF/ID register.
module fetch_stage
  import riscv_pkg::fetch_state_t;
  import riscv_pkg::ifid_t;
  import riscv_pkg::BOOT;
  import riscv_pkg::RUN;
#(
  parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC,
  parameter int unsigned ROM_AW    = 10,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              STALL,
  input  logic              BRANCH_TAKEN,
  input  logic [31:0]       BRANCH_TARGET,
  output logic [ROM_AW-1:0] INSTRUCTION_ADDRESS,
  input  logic [31:0]       INSTRUCTION,
  output logic [31:0]       PC_IF,
  output logic [31:0]       PC_ID,
  output logic [31:0]       INSTR_ID,
  output logic              VALID_ID,
  output logic              MISALIGNED
);

  fetch_state_t state_d, state_q;
  logic [31:0]  pc_d, pc_q;
  logic         mis_d, mis_q;
  logic         ifid_hold, ifid_flush;
  ifid_t        ifid_in, ifid_out;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mis_d      = 1'b0;
    ifid_hold  = 1'b1;
    ifid_flush = 1'b0;
    unique case (state_q)
      // The first edge out of reset commits nothing so the ROM output settles.
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (BRANCH_TAKEN) begin
          pc_d       = {BRANCH_TARGET[31:2], 2'b00};
          mis_d      = |BRANCH_TARGET[1:0];
          ifid_flush = 1'b1;
        end else if (!STALL) begin
          pc_d      = pc_q + 32'd4;
          ifid_hold = 1'b0;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    ifid_in.pc    = pc_q;
    ifid_in.instr = INSTRUCTION;
    ifid_in.valid = 1'b1;
  end

  ifid_reg #(
    .RstPc      (RESET_PC),
    .BubbleInstr(NOP_INSTR)
  ) u_ifid_reg (
    .clk_i  (CLK),
    .rst_ni (RST_n),
    .hold_i (ifid_hold),
    .flush_i(ifid_flush),
    .d_i    (ifid_in),
    .q_o    (ifid_out)
  );

  assign INSTRUCTION_ADDRESS = pc_q[ROM_AW+1:2];
  assign PC_IF               = pc_q;
  assign PC_ID               = ifid_out.pc;
  assign INSTR_ID            = ifid_out.instr;
  assign VALID_ID            = ifid_out.valid;
  assign MISALIGNED          = mis_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural combinational ROM.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        br;
  logic [31:0] target;
  logic [9:0]  iaddr;
  logic [31:0] instr;
  logic [31:0] pc_if, pc_id, instr_id;
  logic        valid_id, misaligned;

  logic [31:0] rom [1024];
  assign instr = rom[iaddr];

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .ROM_AW   (10),
    .NOP_INSTR(NOP)
  ) dut (
    .CLK                (clk),
    .RST_n              (rst_n),
    .STALL              (stall),
    .BRANCH_TAKEN       (br),
    .BRANCH_TARGET      (target),
    .INSTRUCTION_ADDRESS(iaddr),
    .INSTRUCTION        (instr),
    .PC_IF              (pc_if),
    .PC_ID              (pc_id),
    .INSTR_ID           (instr_id),
    .VALID_ID           (valid_id),
    .MISALIGNED         (misaligned)
  );

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] target;
    logic [31:0] pc_if;
    logic [9:0]  addr;
    logic [31:0] pc_id;
    logic [31:0] instr;
    logic        valid;
    logic        mis;
  } vec_t;

  vec_t vecs [17];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc_if, input logic [9:0] e_addr,
                         input logic [31:0] e_pc_id, input logic [31:0] e_instr,
                         input logic e_valid, input logic e_mis);
    chk({tag, ".PC_IF"}, pc_if, e_pc_if);
    chk({tag, ".ADDR"}, {22'd0, iaddr}, {22'd0, e_addr});
    chk({tag, ".PC_ID"}, pc_id, e_pc_id);
    chk({tag, ".INSTR_ID"}, instr_id, e_instr);
    chk({tag, ".VALID_ID"}, {31'd0, valid_id}, {31'd0, e_valid});
    chk({tag, ".MISALIGNED"}, {31'd0, misaligned}, {31'd0, e_mis});
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'hA000_0000 | i;
    rom[0] = 32'h0050_0093;
    rom[1] = 32'h00A0_0113;

    //          stall br  target         pc_if          addr     pc_id          instr          v     mis
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        32'h0000_0000, 10'h000, 32'h0000_0000, NOP,           1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        32'h0000_0004, 10'h001, 32'h0000_0000, 32'h0050_0093, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,        32'h0000_0008, 10'h002, 32'h0000_0004, 32'h00A0_0113, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,        32'h0000_0008, 10'h002, 32'h0000_0004, 32'h00A0_0113, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,        32'h0000_0008, 10'h002, 32'h0000_0004, 32'h00A0_0113, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,        32'h0000_0008, 10'h002, 32'h0000_0004, 32'h00A0_0113, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,        32'h0000_000C, 10'h003, 32'h0000_0008, 32'hA000_0002, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_0040, 32'h0000_0040, 10'h010, 32'h0000_0008, NOP,           1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,        32'h0000_0044, 10'h011, 32'h0000_0040, 32'hA000_0010, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 32'h0000_0022, 32'h0000_0020, 10'h008, 32'h0000_0040, NOP,           1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 32'h0,        32'h0000_0024, 10'h009, 32'h0000_0020, 32'hA000_0008, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h0000_0FFC, 10'h3FF, 32'h0000_0020, NOP,           1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 32'h0,        32'h0000_1000, 10'h000, 32'h0000_0FFC, 32'hA000_03FF, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 32'h0,        32'h0000_1004, 10'h001, 32'h0000_1000, 32'h0050_0093, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 10'h3FF, 32'h0000_1000, NOP,           1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 32'h0,        32'h0000_0000, 10'h000, 32'hFFFF_FFFC, 32'hA000_03FF, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 32'h0000_0040, 32'h0000_0040, 10'h010, 32'hFFFF_FFFC, NOP,           1'b0, 1'b0};

    rst_n  = 1'b0;
    stall  = 1'b0;
    br     = 1'b0;
    target = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 32'h0, 10'h000, 32'h0, NOP, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      stall  = vecs[i].stall;
      br     = vecs[i].br;
      target = vecs[i].target;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].pc_if, vecs[i].addr, vecs[i].pc_id,
              vecs[i].instr, vecs[i].valid, vecs[i].mis);
    end

    // Asynchronous reset between edges, with a redirect and stall pending.
    stall  = 1'b1;
    br     = 1'b1;
    target = 32'h0000_0081;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 32'h0, 10'h000, 32'h0, NOP, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("rst_held", 32'h0, 10'h000, 32'h0, NOP, 1'b0, 1'b0);
    rst_n = 1'b1;

    // STALL and BRANCH_TAKEN are ignored on the BOOT edge.
    @(posedge clk);
    #1;
    chk_all("boot_ignore", 32'h0, 10'h000, 32'h0, NOP, 1'b0, 1'b0);
    stall = 1'b0;
    br    = 1'b0;
    @(posedge clk);
    #1;
    chk_all("restart0", 32'h4, 10'h001, 32'h0, 32'h0050_0093, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk_all("restart1", 32'h8, 10'h002, 32'h4, 32'h00A0_0113, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
